// File: rtl/sram_resp.sv
// Single-port SRAM responder with a one-entry posted write buffer and 1-cycle registered reads.
// Optional read/write request counters are enabled by defining SRAM_PERF_CNT_EN.
module sram_resp #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        wbuf_pending,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Byte-wise select: take bytes of 'upd' where 'be' is set, else keep 'base'.
  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] upd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = upd[8*i +: 8];
      end else begin
        res[8*i +: 8] = base[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]           mem_q [DEPTH];

  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_word_q,  buf_word_d;
  logic [3:0]            buf_be_q,    buf_be_d;
  logic [31:0]           buf_data_q,  buf_data_d;
  logic [31:0]           rdata_q,     rdata_d;

  logic [ADDR_WIDTH-1:0] word_s;
  logic                  rd_req_s;
  logic                  wr_req_s;
  logic                  hit_s;
  logic                  commit_s;
  logic                  unused_addr_s;

  assign word_s        = sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_s = ^{sram_addr[31:ADDR_WIDTH+2], sram_addr[1:0]};
  assign rd_req_s      = sram_en & (sram_wen == 4'h0);
  assign wr_req_s      = sram_en & (sram_wen != 4'h0);
  assign hit_s         = buf_valid_q & (buf_word_q == word_s);
  // The buffered entry goes to the array when it is evicted by a different word or on an idle cycle.
  assign commit_s      = buf_valid_q & ((wr_req_s & ~hit_s) | ~sram_en);

  // Next-state for the write buffer and read data register.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_be_d    = buf_be_q;
    buf_data_d  = buf_data_q;
    rdata_d     = rdata_q;
    if (rd_req_s) begin
      if (hit_s) begin
        rdata_d = merge_bytes(mem_q[word_s], buf_data_q, buf_be_q);
      end else begin
        rdata_d = mem_q[word_s];
      end
    end else if (wr_req_s) begin
      buf_valid_d = 1'b1;
      if (hit_s) begin
        buf_data_d = merge_bytes(buf_data_q, sram_wdata, sram_wen);
        buf_be_d   = buf_be_q | sram_wen;
      end else begin
        buf_word_d = word_s;
        buf_be_d   = sram_wen;
        buf_data_d = sram_wdata;
      end
    end else begin
      buf_valid_d = 1'b0;
    end
  end

  // Buffer and read-data registers; a pending write is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_be_q    <= 4'h0;
      buf_data_q  <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_be_q    <= buf_be_d;
      buf_data_q  <= buf_data_d;
      rdata_q     <= rdata_d;
    end
  end

  // Storage array: only bytes enabled in the buffered entry are ever written.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_be_q[i]) begin
          mem_q[buf_word_q][8*i +: 8] <= buf_data_q[8*i +: 8];
        end
      end
    end
  end

  assign sram_rdata   = rdata_q;
  assign wbuf_pending = buf_valid_q;

`ifdef SRAM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Request counters wrap naturally at 2**32.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_req_s) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end else if (wr_req_s) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_sram_resp.sv
// Self-checking bench for sram_resp: directed bus scenarios plus randomized traffic
// checked every cycle against a logical-memory reference model.
module tb_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        wbuf_pending;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

`ifdef SRAM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  sram_resp #(.ADDR_WIDTH(14)) dut (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wbuf_pending(wbuf_pending), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Reference: software-visible memory (updated at once on every write), plus a
  // snapshot of the pending word's committed image so a reset can undo it.
  logic [31:0] lmem  [int];
  logic [31:0] kmask [int];
  bit          m_pend_v = 1'b0;
  int          m_pend_w = 0;
  logic [31:0] m_sv = 32'h0, m_svk = 32'h0;
  logic [31:0] m_rd = 32'h0, m_rd_mask = 32'hFFFF_FFFF;
  logic [31:0] m_rdc = 32'h0, m_wrc = 32'h0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (byte mask %h) at %0t", name, act, exp, mask, $time);
    end
  endtask

  function automatic logic [31:0] expand(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic model_step(input bit en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] d);
    int w;
    logic [31:0] old, oldk, bm;
    w    = int'((addr >> 2) & 32'h3FFF);
    old  = lmem.exists(w)  ? lmem[w]  : 32'h0;
    oldk = kmask.exists(w) ? kmask[w] : 32'h0;
    if (!en) begin
      m_pend_v = 1'b0;
    end else if (wen == 4'h0) begin
      m_rd      = old;
      m_rd_mask = oldk;
      m_rdc     = m_rdc + 32'd1;
    end else begin
      if (!(m_pend_v && m_pend_w == w)) begin
        m_sv     = old;
        m_svk    = oldk;
        m_pend_w = w;
        m_pend_v = 1'b1;
      end
      bm       = expand(wen);
      lmem[w]  = (old & ~bm) | (d & bm);
      kmask[w] = oldk | bm;
      m_wrc    = m_wrc + 32'd1;
    end
  endtask

  task automatic model_reset();
    if (m_pend_v) begin
      lmem[m_pend_w]  = m_sv;
      kmask[m_pend_w] = m_svk;
    end
    m_pend_v  = 1'b0;
    m_rd      = 32'h0;
    m_rd_mask = 32'hFFFF_FFFF;
    m_rdc     = 32'h0;
    m_wrc     = 32'h0;
  endtask

  task automatic do_req(input bit en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] d);
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = d;
    @(posedge clk);
    #1;
    model_step(en, wen, addr, d);
  endtask

  // Async reset pulse starting between edges; outputs must clear without an edge.
  task automatic async_reset(input bit pin);
    sram_en = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    if (pin) begin
      check("async_rst_rdata", sram_rdata, 32'h0, 32'hFFFF_FFFF);
      check("async_rst_pending", {31'h0, wbuf_pending}, 32'h0, 32'hFFFF_FFFF);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (cmp_on) begin
      if (m_rd_mask != 32'h0) begin
        check("rdata", sram_rdata, m_rd, m_rd_mask);
      end
      check("wbuf_pending", {31'h0, wbuf_pending}, {31'h0, m_pend_v}, 32'hFFFF_FFFF);
      check("rd_cnt", rd_cnt, PERF ? m_rdc : 32'h0, 32'hFFFF_FFFF);
      check("wr_cnt", wr_cnt, PERF ? m_wrc : 32'h0, 32'hFFFF_FFFF);
    end
  end

  initial begin
    rst        = 1'b1;
    sram_en    = 1'b0;
    sram_wen   = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_on = 1'b1;
    check("reset_rdata", sram_rdata, 32'h0, 32'hFFFF_FFFF);
    check("reset_pending", {31'h0, wbuf_pending}, 32'h0, 32'hFFFF_FFFF);

    // Store then immediate load of the same word.
    do_req(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
    check("st_pending", {31'h0, wbuf_pending}, 32'h1, 32'hFFFF_FFFF);
    do_req(1'b1, 4'h0, 32'h0000_1000, 32'h0);
    check("ld_after_st", sram_rdata, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    check("ld_pending", {31'h0, wbuf_pending}, 32'h1, 32'hFFFF_FFFF);
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    check("drain_pending", {31'h0, wbuf_pending}, 32'h0, 32'hFFFF_FFFF);
    check("idle_holds", sram_rdata, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

    // Partial store merged over drained array contents.
    do_req(1'b1, 4'hF, 32'h0000_1004, 32'h1122_3344);
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b1, 4'b0010, 32'h0000_1004, 32'h0000_AA00);
    do_req(1'b1, 4'h0, 32'h0000_1004, 32'h0);
    check("byte_merge", sram_rdata, 32'h1122_AA44, 32'hFFFF_FFFF);
    check("model_byte_merge", m_rd, 32'h1122_AA44, 32'hFFFF_FFFF);

    // Coalescing two partial stores to one word via aliased addresses.
    do_req(1'b1, 4'hF, 32'h0000_1008, 32'h5566_7788);
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b1, 4'b0001, 32'h0000_1008, 32'h0000_00AB);
    do_req(1'b1, 4'b1000, 32'h0000_100A, 32'hCD00_0000);
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b1, 4'h0, 32'h0000_1008, 32'h0);
    check("coalesce", sram_rdata, 32'hCD66_77AB, 32'hFFFF_FFFF);

    // Back-to-back stores to different words, then loads.
    do_req(1'b1, 4'hF, 32'h0000_2000, 32'h1);
    do_req(1'b1, 4'hF, 32'h0000_3000, 32'h2);
    do_req(1'b1, 4'h0, 32'h0000_2000, 32'h0);
    check("b2b_first", sram_rdata, 32'h1, 32'hFFFF_FFFF);
    do_req(1'b1, 4'h0, 32'h0000_3000, 32'h0);
    check("b2b_second", sram_rdata, 32'h2, 32'hFFFF_FFFF);

    // Reset discards a buffered store.
    do_req(1'b1, 4'hF, 32'h0000_4000, 32'h0);
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b1, 4'hF, 32'h0000_4000, 32'h55);
    async_reset(1'b1);
    do_req(1'b1, 4'h0, 32'h0000_4000, 32'h0);
    check("rst_discard", sram_rdata, 32'h0, 32'hFFFF_FFFF);

    // Counter scenario: three loads and two stores since the reset above.
    do_req(1'b1, 4'h0, 32'h0000_1000, 32'h0);
    do_req(1'b1, 4'hF, 32'h0000_5000, 32'h7);
    do_req(1'b1, 4'h0, 32'h0000_1004, 32'h0);
    do_req(1'b1, 4'h3, 32'h0000_5000, 32'h9);
    check("cnt_rd", rd_cnt, PERF ? 32'd3 : 32'd0, 32'hFFFF_FFFF);
    check("cnt_wr", wr_cnt, PERF ? 32'd2 : 32'd0, 32'hFFFF_FFFF);

    // Randomized traffic over 16 words with random alias bits.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 99));
      a = ($urandom & 32'hFFFF_0003) | (32'h0000_1000 + ($urandom_range(0, 15) << 2));
      if (r < 1) begin
        async_reset(1'b0);
      end else if (r < 30) begin
        do_req(1'b0, 4'($urandom), a, $urandom);
      end else if (r < 65) begin
        do_req(1'b1, 4'h0, a, $urandom);
      end else begin
        do_req(1'b1, 4'($urandom_range(1, 15)), a, $urandom);
      end
    end

    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_resp.md
Name: sram_resp

Overview:
- Synchronous single-port memory that acts as the responder on the core's SRAM-style bus: en, wen[3:0], addr, wdata in; rdata out.
- Serves as the instruction or data memory behind the CPU core, in simulation and FPGA builds.
- Holds a 1-entry posted write buffer, so a read issued right after a store sees the stored bytes without a stall; the bus protocol has no stall signal.
- Byte write enables, fixed 1-cycle read latency.

Parameters:
- ADDR_WIDTH, 14, word-index bits; array depth = 2**ADDR_WIDTH words of 32 bits.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- sram_en  input  1  request valid this cycle
- sram_wen  input  4  byte write enables; 0 = read, nonzero = write (bit i -> wdata[8i+7:8i])
- sram_addr  input  32  byte address; word index = sram_addr[ADDR_WIDTH+1:2]; bits [1:0] and upper bits ignored
- sram_wdata  input  32  write data
- sram_rdata  output  32  read data, registered
- wbuf_pending  output  1  write buffer holds an undrained write
- rd_cnt  output  32  read-request count (macro-dependent)
- wr_cnt  output  32  write-request count (macro-dependent)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: sram_rdata=0, wbuf_pending=0, rd_cnt=0, wr_cnt=0, buffer valid=0. The array is not reset.
- Reset mid-operation: a buffered write is discarded and never reaches the array.
- Idle cycle (sram_en=0): wen/addr/wdata ignored; sram_rdata holds its value.
- Read (en=1, wen=0) at edge N: sram_rdata is valid after edge N and holds until the next read. The array is read this cycle.
- Read data with buffer valid and buffer word == read word: per-byte merge; byte i comes from the buffer if buf_be[i], else from the array.
- Read data in all other cases: straight array data.
- The buffer never drains on a read cycle.
- Write (en=1, wen!=0), buffer empty: capture {word, wen, wdata} into the buffer; valid=1.
- Write, buffer valid, same word: coalesce with no array write. Bytes with new wen[i] are overwritten; buf_be |= wen.
- Write, buffer valid, different word: commit the old entry to the array (bytes per buf_be) and capture the new write, same edge.
- Drain: on an idle cycle with buffer valid, commit the entry to the array; valid=0.
- Array port: at most one access (read or write) per cycle. The array never sees a partial write outside buf_be.
- Write cycles leave sram_rdata unchanged.
- wbuf_pending equals buffer valid.
- Counters (macro enabled only): rd_cnt increments on each accepted read; wr_cnt on each accepted write, coalesced ones included. Both wrap at 2**32 to 0.
- Address aliasing: any two addresses with equal word index refer to the same word.

Optional Feature:
- SRAM_PERF_CNT_EN
- Defined: rd_cnt and wr_cnt count as described above.
- Undefined: both ports are tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Reset asserted asynchronously between edges -> sram_rdata=0 and wbuf_pending=0 immediately, without waiting for an edge.
- Write 0x0000_1000 wen=4'hF data=0xDEADBEEF, next cycle read 0x1000 -> rdata=0xDEADBEEF after that edge. wbuf_pending stays 1 through the read, then drops after the first idle cycle.
- Array word 0x1004 = 0x11223344 (drained). Write 0x1004 wen=4'b0010 data=0x0000AA00, then read 0x1004 -> rdata=0x1122AA44.
- Coalesce: write 0x1008 wen=4'b0001 data=0x000000AB, then write 0x100A wen=4'b1000 data=0xCD000000, idle, read 0x1008 -> rdata = 0xCD??_??AB, with the middle bytes equal to prior array contents.
- Back-to-back writes to 0x2000 and 0x3000 (data 1, 2), then reads of 0x2000 and 0x3000 -> rdata 1 then 2. The first write is committed on the second write's edge.
- Reset while buffer holds write 0x4000=0x55 over array value 0x0: deassert, read 0x4000 -> 0x0.
- With SRAM_PERF_CNT_EN: 3 reads + 2 writes -> rd_cnt=3, wr_cnt=2. Without the macro -> both 0.
